// File: rtl/irq_agg_pkg.sv
// Shared constants for the interrupt aggregator: register map and bus width.
package irq_agg_pkg;
  localparam int DATA_W           = 16;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_ENABLE   = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_RAW      = 3'd4;
  localparam logic [2:0] ADDR_HOLDOFF  = 3'd5;
endpackage

// File: rtl/irq_aggregator_if.sv
// 16-bit register bus (Avalon-MM style) between the CPU fabric and the aggregator.
interface irq_aggregator_if;
  import irq_agg_pkg::*;

  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; idx is 0 when nothing is requested.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source pending latch, enable mask, level/edge select,
// priority readout and one registered irq. Optional IRQ_AGG_HOLDOFF_EN adds a re-arm holdoff.
module irq_aggregator
    import irq_agg_pkg::*;
#(
    parameter int                N_SRC        = 4,
    parameter logic [DATA_W-1:0] RESET_ENABLE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    irq_aggregator_if.slave  bus,
    input  logic [N_SRC-1:0] irq_in,
    output logic             irq
);

    logic [N_SRC-1:0]  pending, enable, edge_sel, irq_in_d;
    logic [N_SRC-1:0]  rise, set_bits, clr_bits;
    logic              wr, wr_pend;
    logic              act_vld;
    logic [3:0]        act_idx;
    logic [DATA_W-1:0] rd_mux;
    logic              irq_nxt;
    logic              unused_wdata;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_pend  = wr && (bus.address == ADDR_PENDING);
    assign rise     = irq_in & ~irq_in_d;
    assign set_bits = (edge_sel & rise) | (~edge_sel & irq_in);
    assign clr_bits = wr_pend ? bus.writedata[N_SRC-1:0] : '0;

    assign unused_wdata = ^bus.writedata;

    irq_prio_enc #(.N(N_SRC)) u_prio (
        .req   (pending & enable),
        .valid (act_vld),
        .idx   (act_idx)
    );

`ifdef IRQ_AGG_HOLDOFF_EN
    logic [DATA_W-1:0] holdoff, hold_cnt;

    // Any PENDING write (re)arms the holdoff so the handler's W1C cannot instantly re-fire irq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdoff  <= '0;
            hold_cnt <= '0;
        end else begin
            if (wr && bus.address == ADDR_HOLDOFF) holdoff <= bus.writedata;
            if (wr_pend)              hold_cnt <= holdoff;
            else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign irq_nxt = (|(pending & enable)) && (hold_cnt == '0);
`else
    assign irq_nxt = |(pending & enable);
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_PENDING:  rd_mux[N_SRC-1:0] = pending;
            ADDR_ENABLE:   rd_mux[N_SRC-1:0] = enable;
            ADDR_EDGE_SEL: rd_mux[N_SRC-1:0] = edge_sel;
            ADDR_ACTIVE: begin
                rd_mux[ACTIVE_VALID_BIT] = act_vld;
                rd_mux[3:0]              = act_idx;
            end
            ADDR_RAW:      rd_mux[N_SRC-1:0] = irq_in;
`ifdef IRQ_AGG_HOLDOFF_EN
            ADDR_HOLDOFF:  rd_mux = holdoff;
`endif
            default:       rd_mux = '0;
        endcase
    end

    // Set beats a simultaneous clear, so a still-asserted level source survives W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            enable       <= RESET_ENABLE[N_SRC-1:0];
            edge_sel     <= '0;
            irq_in_d     <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            irq_in_d     <= irq_in;
            pending      <= set_bits | (pending & ~clr_bits);
            if (wr && bus.address == ADDR_ENABLE)   enable   <= bus.writedata[N_SRC-1:0];
            if (wr && bus.address == ADDR_EDGE_SEL) edge_sel <= bus.writedata[N_SRC-1:0];
            bus.readdata <= rd_mux;
            irq          <= irq_nxt;
        end
    end

endmodule
